inner_acc: RTL and testbench

Parametrised, fully pipelined fixed-point dot-product engine. Successor to the fixed 24-lane inner-product unit in the dense layer. Generalises lane count, adds valid/last multi-beat accumulation for vectors longer than one beat, and keeps products at full precision through the adder tree with a single rounding step. Sits between the weight/activation fetch path and the dense-layer activation stage; one instance per output neuron lane.

---
 rtl/inner_acc_pkg.sv | 64 ++++++
 rtl/inner_acc_add_tree.sv | 67 ++++++
 rtl/inner_acc.sv | 151 +++++++++++++++
 tb/tb_inner_acc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/inner_acc_pkg.sv
// Shared definitions for the inner_acc dot-product engine: defaults, width
// derivation, accumulator FSM states and the round/saturate helper.
package inner_acc_pkg;

  localparam int N_LEN_DEF = 16;
  localparam int F_LEN_DEF = 8;
  localparam int WIDE      = 128;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } acc_state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int acc_width(input int n_len, input int lanes, input int max_beats);
    return 2 * n_len + clog2(lanes) + clog2(max_beats);
  endfunction

  // Node count of adder-tree level `level` (level 0 = the lane inputs).
  function automatic int tree_nodes(input int lanes, input int level);
    int n;
    n = lanes;
    for (int i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  // Round half up, arithmetic shift by f_len, optionally clamp to n_len signed.
  function automatic logic signed [WIDE-1:0] round_sat(
    input  logic signed [WIDE-1:0] a,
    input  int                     f_len,
    input  int                     n_len,
    input  bit                     sat_en,
    output logic                   sat_o
  );
    logic signed [WIDE-1:0] one;
    logic signed [WIDE-1:0] r;
    logic signed [WIDE-1:0] hi;
    logic signed [WIDE-1:0] lo;
    one    = '0;
    one[0] = 1'b1;
    if (f_len > 0) r = (a + (one <<< (f_len - 1))) >>> f_len;
    else           r = a;
    hi    = (one <<< (n_len - 1)) - one;
    lo    = ~hi;
    sat_o = 1'b0;
    if (sat_en && (r > hi)) begin
      r     = hi;
      sat_o = 1'b1;
    end else if (sat_en && (r < lo)) begin
      r     = lo;
      sat_o = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/inner_acc_add_tree.sv
// Registered binary adder tree: LANES signed inputs of IN_W bits, one register
// level per tree level, width grows one bit per level, latency clog2(LANES).
module add_tree
  import inner_acc_pkg::*;
#(
  parameter int LANES = 24,
  parameter int IN_W  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_valid,
  input  logic                               i_last,
  input  logic [LANES*IN_W-1:0]              i_data,
  output logic                               o_valid,
  output logic                               o_last,
  output logic signed [IN_W+clog2(LANES)-1:0] o_sum
);

  localparam int D = clog2(LANES);

  for (genvar k = 0; k <= D; k++) begin : g_lvl
    localparam int W  = IN_W + k;
    localparam int N  = tree_nodes(LANES, k);
    localparam int PN = tree_nodes(LANES, k - 1);

    logic r_v;
    logic r_l;

    for (genvar j = 0; j < N; j++) begin : g_n
      logic signed [W-1:0] r_node;
      if (k == 0) begin : g_in
        assign r_node = i_data[j*IN_W +: IN_W];
      end else if (2 * j + 1 < PN) begin : g_pair
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_node <= '0;
          else     r_node <= W'(g_lvl[k-1].g_n[2*j].r_node) + W'(g_lvl[k-1].g_n[2*j+1].r_node);
        end
      end else begin : g_pass
        // Odd node out at this level is carried up unchanged.
        always_ff @(posedge clk or posedge rst) begin
          if (rst) r_node <= '0;
          else     r_node <= W'(g_lvl[k-1].g_n[2*j].r_node);
        end
      end
    end

    if (k == 0) begin : g_v0
      assign r_v = i_valid;
      assign r_l = i_last;
    end else begin : g_v
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_v <= 1'b0;
          r_l <= 1'b0;
        end else begin
          r_v <= g_lvl[k-1].r_v;
          r_l <= g_lvl[k-1].r_l;
        end
      end
    end
  end

  assign o_sum   = g_lvl[D].g_n[0].r_node;
  assign o_valid = g_lvl[D].r_v;
  assign o_last  = g_lvl[D].r_l;

endmodule

// File: rtl/inner_acc.sv
// Pipelined fixed-point dot-product engine with multi-beat accumulation.
// Define INNER_ACC_SAT_EN to clamp the narrowed result instead of wrapping.
module inner_acc
  import inner_acc_pkg::*;
#(
  parameter int LANES     = 24,
  parameter int N_LEN     = N_LEN_DEF,
  parameter int F_LEN     = F_LEN_DEF,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [LANES*N_LEN-1:0]   d1,
  input  logic [LANES*N_LEN-1:0]   d2,
  output logic                     out_valid,
  output logic signed [N_LEN-1:0]  q,
  output logic                     sat,
  output logic                     ovf,
  output acc_state_t               o_dbg_state
);

  localparam int D      = clog2(LANES);
  localparam int PROD_W = 2 * N_LEN;
  localparam int SUM_W  = PROD_W + D;
  localparam int ACC_W  = acc_width(N_LEN, LANES, MAX_BEATS);
  localparam int CNT_W  = (clog2(MAX_BEATS) + 1 > 5) ? clog2(MAX_BEATS) + 1 : 5;
`ifdef INNER_ACC_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Stage M: full-precision lane products.
  logic signed [PROD_W-1:0] r_prod [LANES];
  logic                     r_m_valid;
  logic                     r_m_last;
  logic [LANES*PROD_W-1:0]  w_prod_flat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      for (int i = 0; i < LANES; i++) r_prod[i] <= '0;
    end else begin
      r_m_valid <= in_valid;
      r_m_last  <= in_valid & in_last;
      for (int i = 0; i < LANES; i++) begin
        r_prod[i] <= PROD_W'(signed'(d1[i*N_LEN +: N_LEN])) *
                     PROD_W'(signed'(d2[i*N_LEN +: N_LEN]));
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_pack
    assign w_prod_flat[i*PROD_W +: PROD_W] = r_prod[i];
  end

  // Stage T
  logic                    w_t_valid;
  logic                    w_t_last;
  logic signed [SUM_W-1:0] w_sum;

  add_tree #(
    .LANES (LANES),
    .IN_W  (PROD_W)
  ) u_tree (
    .clk     (clk),
    .rst     (rst),
    .i_valid (r_m_valid),
    .i_last  (r_m_last),
    .i_data  (w_prod_flat),
    .o_valid (w_t_valid),
    .o_last  (w_t_last),
    .o_sum   (w_sum)
  );

  // Stage A: accumulator FSM; r_a_done marks the cycle r_acc holds a final sum.
  acc_state_t              r_state;
  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_next;
  logic                    r_a_done;
  logic                    r_a_ovf;

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_state == S_IDLE)   w_cnt_next = CNT_W'(1);
    else if (r_cnt != '1)    w_cnt_next = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_a_done <= 1'b0;
      r_a_ovf  <= 1'b0;
    end else begin
      r_a_done <= w_t_valid & w_t_last;
      if (w_t_valid) begin
        r_acc <= (r_state == S_IDLE) ? ACC_W'(w_sum) : r_acc + ACC_W'(w_sum);
        if (w_t_last) begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_a_ovf <= (int'(w_cnt_next) > MAX_BEATS);
        end else begin
          r_state <= S_ACCUM;
          r_cnt   <= w_cnt_next;
        end
      end
    end
  end

  assign o_dbg_state = r_state;

  // Stage O: single rounding step, then narrow.
  logic signed [WIDE-1:0] w_acc_wide;
  logic signed [WIDE-1:0] w_round;
  logic                   w_sat;
  logic                   w_unused_round;

  always_comb begin
    w_acc_wide = WIDE'(r_acc);
    w_round    = round_sat(w_acc_wide, F_LEN, N_LEN, SAT_EN, w_sat);
  end

  assign w_unused_round = ^{w_round[WIDE-1:N_LEN], w_sat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
      sat       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= r_a_done;
      if (r_a_done) begin
        q   <= w_round[N_LEN-1:0];
`ifdef INNER_ACC_SAT_EN
        sat <= w_sat;
`else
        sat <= 1'b0;
`endif
        ovf <= r_a_ovf;
      end
    end
  end

endmodule

// File: tb/tb_inner_acc.sv
// Directed bench for inner_acc: a 24-lane instance for the main datapath and a
// 1-lane instance for rounding; results checked against an expected queue.
module tb_inner_acc;
  import inner_acc_pkg::*;

  localparam int LANES = 24;
  localparam int N     = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic               in_valid, in_last;
  logic [LANES*N-1:0] d1, d2;
  logic               out_valid, sat, ovf;
  logic [N-1:0]       q;
  acc_state_t         dbg0;

  logic               in_valid1, in_last1;
  logic [N-1:0]       d1_1, d2_1;
  logic               out_valid1, sat1, ovf1;
  logic [N-1:0]       q1;
  acc_state_t         dbg1;

  int    n_vec = 0;
  int    n_bad = 0;
  int    cyc   = 0;
  int    last_drive;
  string cur_test = "reset";

  logic [N+1:0] exp_q[$];
  logic [N+1:0] exp1_q[$];
  int           pulse_q[$];
  int           pulse1_q[$];

  inner_acc #(.LANES(LANES)) dut (
    .clk (clk), .rst (rst), .in_valid (in_valid), .in_last (in_last),
    .d1 (d1), .d2 (d2), .out_valid (out_valid), .q (q), .sat (sat), .ovf (ovf),
    .o_dbg_state (dbg0)
  );

  inner_acc #(.LANES(1)) dut1 (
    .clk (clk), .rst (rst), .in_valid (in_valid1), .in_last (in_last1),
    .d1 (d1_1), .d2 (d2_1), .out_valid (out_valid1), .q (q1), .sat (sat1), .ovf (ovf1),
    .o_dbg_state (dbg1)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h expected %0h", cur_test, tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic beat(input logic [N-1:0] a, input logic [N-1:0] b, input logic last);
    @(negedge clk);
    last_drive = cyc;
    in_valid   = 1'b1;
    in_last    = last;
    for (int i = 0; i < LANES; i++) begin
      d1[i*N +: N] = a;
      d2[i*N +: N] = b;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid  = 1'b0;
      in_last   = 1'($urandom_range(0, 1));
      in_valid1 = 1'b0;
      in_last1  = 1'($urandom_range(0, 1));
      for (int i = 0; i < LANES; i++) begin
        d1[i*N +: N] = 16'($urandom());
        d2[i*N +: N] = 16'($urandom());
      end
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 40 && (exp_q.size() + exp1_q.size()) != 0) begin
      @(negedge clk);
      i++;
    end
    repeat (3) @(negedge clk);
    chk("drain", 64'(exp_q.size() + exp1_q.size()), 64'd0);
  endtask

  // scoreboard monitors
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      pulse_q.push_back(cyc);
      if (exp_q.size() == 0) chk("spurious", 64'(out_valid), 64'd0);
      else                   chk("result", 64'({ovf, sat, q}), 64'(exp_q.pop_front()));
    end
    if (!rst && out_valid1) begin
      pulse1_q.push_back(cyc);
      if (exp1_q.size() == 0) chk("spurious1", 64'(out_valid1), 64'd0);
      else                    chk("result1", 64'({ovf1, sat1, q1}), 64'(exp1_q.pop_front()));
    end
  end

  initial begin
    int t0;
    int lat;
    int ra[4];
    int rq[4];
    ra = '{128, 127, -128, -129};
    rq = '{1, 0, 0, -1};
    in_valid = 1'b0; in_last = 1'b0; d1 = '0; d2 = '0;
    in_valid1 = 1'b0; in_last1 = 1'b0; d1_1 = '0; d2_1 = '0;

    repeat (3) @(negedge clk);
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("q", 64'(q), 64'd0);
    chk("sat_ovf", 64'({sat, ovf}), 64'd0);
    chk("state", 64'(dbg0), 64'(S_IDLE));
    chk("out1", 64'({out_valid1, sat1, ovf1, q1}), 64'd0);
    rst = 1'b0;

    cur_test = "single";
    pulse_q.delete();
    exp_q.push_back({2'b00, 16'd3072});
    beat(16'd256, 16'd128, 1'b1);
    t0 = last_drive;
    idle(1);
    drain();
    chk("pulses", 64'(pulse_q.size()), 64'd1);
    lat = (pulse_q.size() > 0) ? pulse_q[0] - t0 : -1;
    chk("latency", 64'(lat), 64'd8);

    cur_test = "b2b";
    pulse_q.delete();
    exp_q.push_back({2'b00, 16'd18432});
    exp_q.push_back({2'b00, 16'd6144});
    beat(16'd256, 16'd256, 1'b0);
    beat(16'd256, 16'd256, 1'b0);
    beat(16'd256, 16'd256, 1'b1);
    beat(16'd256, 16'd256, 1'b1);
    idle(1);
    drain();
    chk("pulses", 64'(pulse_q.size()), 64'd2);
    if (pulse_q.size() == 2) chk("gap", 64'(pulse_q[1] - pulse_q[0]), 64'd1);

    cur_test = "gapped";
    exp_q.push_back({2'b00, 16'd18432});
    beat(16'd256, 16'd256, 1'b0);
    idle(5);
    beat(16'd256, 16'd256, 1'b0);
    idle(3);
    chk("state_mid", 64'(dbg0), 64'(S_ACCUM));
    beat(16'd256, 16'd256, 1'b1);
    idle(1);
    drain();

    cur_test = "overflow";
`ifdef INNER_ACC_SAT_EN
    exp_q.push_back({2'b01, 16'h7FFF});
`else
    exp_q.push_back({2'b00, 16'h8000});
`endif
    beat(16'd25600, 16'd25600, 1'b1);
    idle(1);
    drain();

    cur_test = "beats";
    exp_q.push_back({2'b00, 16'd384});
    exp_q.push_back({2'b10, 16'd408});
    for (int i = 0; i < 16; i++) beat(16'd256, 16'd1, 1'(i == 15));
    for (int i = 0; i < 17; i++) beat(16'd256, 16'd1, 1'(i == 16));
    idle(1);
    drain();
    idle(4);
    chk("hold", 64'({ovf, sat, q}), 64'({2'b10, 16'd408}));

    cur_test = "round";
    pulse1_q.delete();
    for (int i = 0; i < 4; i++) exp1_q.push_back({2'b00, 16'(rq[i])});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) t0 = cyc;
      in_valid1 = 1'b1;
      in_last1  = 1'b1;
      d1_1      = 16'(ra[i]);
      d2_1      = 16'd1;
    end
    idle(1);
    drain();
    chk("pulses1", 64'(pulse1_q.size()), 64'd4);
    lat = (pulse1_q.size() > 0) ? pulse1_q[0] - t0 : -1;
    chk("latency1", 64'(lat), 64'd3);

    cur_test = "rst_mid";
    pulse_q.delete();
    beat(16'd256, 16'd256, 1'b0);
    beat(16'd256, 16'd256, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    chk("out_valid", 64'(out_valid), 64'd0);
    chk("q", 64'(q), 64'd0);
    chk("sat_ovf", 64'({sat, ovf}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back({2'b00, 16'd6144});
    beat(16'd256, 16'd256, 1'b1);
    idle(1);
    drain();
    chk("pulses", 64'(pulse_q.size()), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
